// File: rtl/count_display_pkg.sv
// rtl/count_display_pkg.sv - glyphs, converter states and helpers for count_display
package count_display_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Decimal digit to glyph; anything out of range shows blank
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // One double-dabble iteration on {bcd[11:0], bin[7:0]}: add 3 to nibbles >= 5, then shift left
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] a;
    a = sr;
    for (int i = 0; i < 3; i++) begin
      if (a[8 + 4 * i +: 4] >= 4'd5) begin
        a[8 + 4 * i +: 4] = a[8 + 4 * i +: 4] + 4'd3;
      end
    end
    return {a[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/count_display_if.sv
// rtl/count_display_if.sv - count input and seven-segment display output bundle
interface count_display_if;

  logic [7:0] value;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  // master: the counter side driving value and watching the display pins
  modport master (output value, input seg, input dp, input an);
  // slave: the display back-end
  modport slave (input value, output seg, output dp, output an);

endinterface

// File: rtl/count_display_bin2bcd.sv
// rtl/count_display_bin2bcd.sv - sequential 8-bit binary to 3-digit BCD converter
module bin2bcd
  import count_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  conv_state_e state_q;
  logic [2:0]  cnt_q;
  logic [19:0] sr_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  hund_q;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;

  // Converter FSM: capture, eight dabble iterations, then commit the digits while done is high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sr_q    <= 20'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= {12'd0, bin};
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= dabble_step(sr_q);
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          hund_q  <= sr_q[19:16];
          tens_q  <= sr_q[15:12];
          ones_q  <= sr_q[11:8];
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hund = hund_q;
  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/count_display.sv
// rtl/count_display.sv - 4-digit multiplexed seven-segment back-end; COUNT_DISPLAY_SIGNED_EN selects two's complement display
module count_display
  import count_display_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic           clk,
  input  logic           rst,
  count_display_if.slave dsp
);

  localparam int DIV = CLK_HZ / (NUM_DIGITS * SCAN_HZ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

  logic [7:0]    last_q, last_d;
  logic          pending_q, pending_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          neg_q, neg_d;

  logic          conv_start;
  logic [7:0]    conv_bin;
  logic          conv_busy;
  logic          conv_done;
  logic [3:0]    dig_hund;
  logic [3:0]    dig_tens;
  logic [3:0]    dig_ones;
  logic [6:0]    g_hund;
  logic [6:0]    g_tens;
  logic [6:0]    g_ones;
  logic [6:0]    g_sign;

  // Change detect: start a conversion whenever the input differs from the last captured one
  always_comb begin
    last_d     = last_q;
    pending_d  = pending_q;
    conv_start = (pending_q || (dsp.value != last_q)) && !conv_busy;
    if (conv_start) begin
      last_d    = dsp.value;
      pending_d = 1'b0;
    end
  end

`ifdef COUNT_DISPLAY_SIGNED_EN
  // Sign handling: convert the magnitude and latch the sign on the same edge the digits commit
  always_comb begin
    conv_bin = dsp.value[7] ? (~dsp.value + 8'd1) : dsp.value;
    neg_d    = conv_done ? last_q[7] : neg_q;
    g_sign   = neg_q ? SEG_DASH : SEG_BLANK;
  end
`else
  logic unused_conv_done;
  assign unused_conv_done = conv_done;

  // Unsigned input: converted as-is, leftmost digit never lit
  always_comb begin
    conv_bin = dsp.value;
    neg_d    = 1'b0;
    g_sign   = SEG_BLANK;
  end
`endif

  bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .hund  (dig_hund),
    .tens  (dig_tens),
    .ones  (dig_ones)
  );

  // Scan prescaler: advance the digit index on each terminal count
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == DIV_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
  end

  // Blanking and scan mux: glyph and one-hot-low enable for the current index
  always_comb begin
    g_hund = (dig_hund == 4'd0) ? SEG_BLANK : seg_glyph(dig_hund);
    g_tens = ((dig_hund == 4'd0) && (dig_tens == 4'd0)) ? SEG_BLANK : seg_glyph(dig_tens);
    g_ones = seg_glyph(dig_ones);
    seg_d  = SEG_BLANK;
    an_d   = 4'hF;
    case (idx_q)
      2'd0: begin seg_d = g_ones; an_d = 4'b1110; end
      2'd1: begin seg_d = g_tens; an_d = 4'b1101; end
      2'd2: begin seg_d = g_hund; an_d = 4'b1011; end
      default: begin seg_d = g_sign; an_d = 4'b0111; end
    endcase
  end

  // State and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 8'd0;
      pending_q <= 1'b1;
      presc_q   <= '0;
      idx_q     <= 2'd0;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'hF;
      neg_q     <= 1'b0;
    end else begin
      last_q    <= last_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      neg_q     <= neg_d;
    end
  end

  assign dsp.seg = seg_q;
  assign dsp.an  = an_q;
  assign dsp.dp  = 1'b1;

endmodule
